// File: rtl/bitty_uart_fetcher_if.sv
// UART link bundle: the fetcher drives the tx side, the UART core answers with
// tx_done/rx_done/rx_data.
interface bitty_uart_fetcher_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_done;
  logic [7:0] rx_data;

  modport master (output tx_en, output tx_data, input tx_done, input rx_done, input rx_data);
  modport slave  (input tx_en, input tx_data, output tx_done, output rx_done, output rx_data);
endinterface

// File: rtl/bitty_uart_fetcher.sv
// UART instruction fetcher: sends CMD_READ + address, assembles the reply with
// per-byte timeout and bounded retry, and lends the link to the core when idle.
module bitty_uart_fetcher #(
  parameter int         ADDR_W      = 8,
  parameter int         INSTR_W     = 16,
  parameter int         TIMEOUT_CYC = 65535,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] CMD_READ    = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [ADDR_W-1:0]    fetch_addr,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 fetch_done,
  output logic                 fetch_err,
  output logic                 busy,
  output logic [7:0]           err_count,
  input  logic                 core_sel,
  input  logic                 core_tx_en,
  input  logic [7:0]           core_tx_data,
  output logic                 core_rx_done,
  bitty_uart_fetcher_if.master uart
);
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int TX_BYTES   = ADDR_BYTES + 1;
  localparam int RX_BYTES   = INSTR_W / 8;
  localparam int TXI_W      = $clog2(TX_BYTES);
  localparam int RXI_W      = $clog2(RX_BYTES + 1);
  localparam int RTY_W      = $clog2(MAX_RETRY + 2);
  localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TXI_W-1:0] TX_LAST  = TXI_W'(TX_BYTES - 1);
  localparam logic [RXI_W-1:0] RX_LAST  = RXI_W'(RX_BYTES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, DONE, ERR} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [TXI_W-1:0]     tx_idx_reg, tx_idx_next;
  logic [RXI_W-1:0]     rx_idx_reg, rx_idx_next;
  logic [RTY_W-1:0]     retry_reg, retry_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [INSTR_W-1:0]   shift_reg, shift_next;
  logic [INSTR_W-1:0]   instr_reg, instr_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic                 busy_reg, busy_next;
  logic [7:0]           err_cnt_reg, err_cnt_next;

  logic [ADDR_BYTES*8-1:0] addr_pad;
  logic [7:0]              tx_bytes [TX_BYTES];
  logic [INSTR_W-1:0]      shift_in;
  logic                    link_core;

  // Byte 0 is the command; the zero-padded address follows MSB first.
  assign addr_pad    = (ADDR_BYTES*8)'(addr_reg);
  assign tx_bytes[0] = CMD_READ;
  generate
    for (genvar gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr_byte
      assign tx_bytes[gi+1] = addr_pad[(ADDR_BYTES-1-gi)*8 +: 8];
    end
    if (INSTR_W == 8) begin : g_shift_byte
      assign shift_in = uart.rx_data;
    end else begin : g_shift_word
      assign shift_in = {shift_reg[INSTR_W-9:0], uart.rx_data};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      tx_idx_reg  <= '0;
      rx_idx_reg  <= '0;
      retry_reg   <= '0;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      instr_reg   <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      tx_idx_reg  <= tx_idx_next;
      rx_idx_reg  <= rx_idx_next;
      retry_reg   <= retry_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      instr_reg   <= instr_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    tx_idx_next  = tx_idx_reg;
    rx_idx_next  = rx_idx_reg;
    retry_next   = retry_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    instr_next   = instr_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    err_cnt_next = err_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (fetch_req && !core_sel) begin
          addr_next   = fetch_addr;
          tx_idx_next = '0;
          retry_next  = '0;
          state_next  = SEND;
        end
      end
      SEND: state_next = WAIT_TX;
      WAIT_TX: begin
        if (uart.tx_done) begin
          if (tx_idx_reg == TX_LAST) begin
            rx_idx_next = '0;
            cnt_next    = '0;
            shift_next  = '0;
            state_next  = RECV;
          end else begin
            tx_idx_next = tx_idx_reg + 1'b1;
            state_next  = SEND;
          end
        end
      end
      RECV: begin
        // A byte arriving on the timeout cycle wins over the timeout.
        if (uart.rx_done) begin
          shift_next  = shift_in;
          rx_idx_next = rx_idx_reg + 1'b1;
          cnt_next    = '0;
          if (rx_idx_reg == RX_LAST) begin
            instr_next = shift_in;
            done_next  = 1'b1;
            state_next = DONE;
          end
        end else if (cnt_reg == CNT_LAST) begin
          if (retry_reg < RTY_MAX) begin
            retry_next  = retry_reg + 1'b1;
            tx_idx_next = '0;
            shift_next  = '0;
            state_next  = SEND;
          end else begin
            err_next = 1'b1;
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_next = err_cnt_reg + 1'b1;
            end
            state_next = ERR;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Only the idle passthrough is combinational; everything else comes from registers.
  assign link_core    = (state_reg == IDLE) && core_sel;
  assign uart.tx_en   = (state_reg == SEND) || (link_core && core_tx_en);
  assign uart.tx_data = link_core ? core_tx_data : tx_bytes[tx_idx_reg];
  assign core_rx_done = link_core && uart.rx_done;

  assign instr_out  = instr_reg;
  assign fetch_done = done_reg;
  assign fetch_err  = err_reg;
  assign busy       = busy_reg;
  assign err_count  = err_cnt_reg;
endmodule

// File: tb/tb_bitty_uart_fetcher.sv
// Randomised bench: the stimulus thread plays the host UART and queues expected
// tx bytes and fetch results; a separate monitor pops and compares them.
module tb_bitty_uart_fetcher;
  localparam int         AW     = 12;
  localparam int         IW     = 32;
  localparam int         TO     = 40;
  localparam int         MR     = 3;
  localparam logic [7:0] CMD    = 8'h03;
  localparam int         AB     = (AW + 7) / 8;
  localparam int         TXB    = AB + 1;
  localparam int         RXB    = IW / 8;
  localparam int         BUDGET = 4 * TO + 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [IW-1:0] instr_out;
  logic          fetch_done, fetch_err, busy;
  logic [7:0]    err_count;
  logic          core_sel = 1'b0, core_tx_en = 1'b0;
  logic [7:0]    core_tx_data = '0;
  logic          core_rx_done;

  bitty_uart_fetcher_if uart_if ();

  bitty_uart_fetcher #(
    .ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR), .CMD_READ(CMD)
  ) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr_out(instr_out), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .busy(busy), .err_count(err_count), .core_sel(core_sel),
    .core_tx_en(core_tx_en), .core_tx_data(core_tx_data),
    .core_rx_done(core_rx_done), .uart(uart_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [IW-1:0] instr;
    logic [7:0]    errc;
  } res_t;

  res_t          exp_res[$];
  logic [7:0]    exp_tx[$];
  int            plan_n[$];
  int            n_cmp = 0, n_bad = 0;
  logic [IW-1:0] model_instr = '0;
  int            model_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // Monitor: compares every fetcher tx byte and every done/err pulse with the queues.
  initial begin
    logic [7:0] e;
    res_t       r;
    forever begin
      @(negedge clk);
      #1;
      if (busy && uart_if.tx_en) begin
        if (exp_tx.size() == 0) note_fail("tx_byte", $sformatf("unexpected tx %02h", uart_if.tx_data));
        else begin
          e = exp_tx.pop_front();
          chk("tx_byte", 32'(uart_if.tx_data), 32'(e));
        end
      end
      if (busy && uart_if.rx_done) chk("core_rx_gate", 32'(core_rx_done), 32'd0);
      if (fetch_done || fetch_err) begin
        if (exp_res.size() == 0) note_fail("result", $sformatf("unexpected pulse done=%0b err=%0b", fetch_done, fetch_err));
        else begin
          r = exp_res.pop_front();
          chk("result_kind", {31'd0, fetch_err}, {31'd0, r.is_err});
          chk("instr_out", instr_out, r.instr);
          chk("err_count", 32'(err_count), 32'(r.errc));
        end
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    core_sel     = 1'($urandom_range(0, 1));
    core_tx_en   = 1'($urandom_range(0, 1));
    core_tx_data = 8'($urandom);
  endtask

  task automatic apply_reset();
    core_sel = 1'b0;
    reset    = 1'b0;
    exp_tx.delete();
    exp_res.delete();
    model_instr = '0;
    model_err   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_tx(output int waited, output bit ok);
    waited = 0;
    while (!(uart_if.tx_en && busy) && waited < BUDGET) begin
      tick();
      waited++;
    end
    ok = uart_if.tx_en && busy;
  endtask

  // One fetch as seen by the host: plan_n[a] bytes answered on attempt a; an
  // attempt with RXB bytes is the successful one. rst_at >= 0 resets mid-reply.
  task automatic do_fetch(input logic [AW-1:0] addr, input logic [IW-1:0] word, input int rst_at);
    int          n_att, waited, g, nb;
    bit          ok, success;
    int unsigned au;
    res_t        r;
    n_att   = plan_n.size();
    success = (plan_n[n_att-1] == RXB);
    au      = 32'(addr);
    for (int a = 0; a < n_att; a++) begin
      exp_tx.push_back(CMD);
      for (int k = AB - 1; k >= 0; k--) exp_tx.push_back(8'((au >> (8 * k)) & 32'hFF));
    end
    if (success) model_instr = word;
    else if (model_err < 255) model_err++;
    r.is_err = !success;
    r.instr  = model_instr;
    r.errc   = 8'(model_err);
    exp_res.push_back(r);

    waited = 0;
    while (busy && waited < BUDGET) begin tick(); waited++; end
    @(negedge clk);
    core_sel   = 1'b0;
    core_tx_en = 1'b0;
    fetch_addr = addr;
    fetch_req  = 1'b1;
    tick();
    fetch_req = 1'b0;

    for (int a = 0; a < n_att; a++) begin
      for (int b = 0; b < TXB; b++) begin
        wait_tx(waited, ok);
        if (!ok) begin
          note_fail("tx_wait", $sformatf("no tx_en for attempt %0d byte %0d", a, b));
          apply_reset();
          return;
        end
        chk("tx_gap", 32'(waited), (a > 0 && b == 0) ? 32'(TO) : 32'd0);
        nb = $urandom_range(1, 3);
        for (int d = 1; d < nb; d++) begin
          tick();
          uart_if.rx_done = 1'($urandom_range(0, 1));
          uart_if.rx_data = 8'($urandom);
        end
        tick();
        uart_if.rx_done = 1'b0;
        uart_if.tx_done = 1'b1;
        tick();
        uart_if.tx_done = 1'b0;
      end
      for (int i = 0; i < plan_n[a]; i++) begin
        if (a == n_att - 1 && i == rst_at) begin
          core_sel = 1'b0;
          reset    = 1'b0;
          #1;
          chk("rst_instr_out", instr_out, 32'd0);
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_err_count", 32'(err_count), 32'd0);
          chk("rst_pulses", {30'd0, fetch_done, fetch_err}, 32'd0);
          exp_tx.delete();
          exp_res.delete();
          model_instr = '0;
          model_err   = 0;
          repeat (2) @(negedge clk);
          reset = 1'b1;
          return;
        end
        if (success && a == n_att - 1 && $urandom_range(0, 4) == 0) g = TO - 1;
        else g = $urandom_range(0, 3);
        repeat (g) tick();
        uart_if.rx_done = 1'b1;
        if (success && a == n_att - 1) uart_if.rx_data = 8'(word >> (8 * (RXB - 1 - i)));
        else uart_if.rx_data = 8'($urandom);
        tick();
        uart_if.rx_done = 1'b0;
      end
    end

    waited = 0;
    while ((exp_res.size() != 0 || busy) && waited < BUDGET) begin tick(); waited++; end
    if (exp_res.size() != 0 || busy) begin
      note_fail("fetch_end", "fetch did not complete in budget");
      apply_reset();
    end else chk("tx_count_left", 32'(exp_tx.size()), 32'd0);
  endtask

  initial begin
    int          sel, nf;
    logic        exp_en;
    uart_if.tx_done = 1'b0;
    uart_if.rx_done = 1'b0;
    uart_if.rx_data = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_instr_out", instr_out, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_pulses", {30'd0, fetch_done, fetch_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    plan_n = '{RXB};
    do_fetch(12'hABC, 32'h01020304, -1);

    plan_n = '{1, RXB};
    do_fetch(12'h5A1, 32'hDEADBEEF, -1);

    plan_n = '{0, 0, 0, 0};
    do_fetch(12'h0F3, 32'h11111111, -1);

    // Core owns the link in IDLE; its fetch request is ignored.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      core_sel        = (i < 8);
      fetch_req       = (i < 8);
      core_tx_en      = 1'($urandom_range(0, 1));
      core_tx_data    = 8'($urandom);
      uart_if.rx_done = 1'($urandom_range(0, 1));
      uart_if.rx_data = 8'($urandom);
      #1;
      exp_en = core_sel && core_tx_en;
      chk("core_tx_en", {31'd0, uart_if.tx_en}, {31'd0, exp_en});
      if (core_sel) chk("core_tx_data", 32'(uart_if.tx_data), 32'(core_tx_data));
      chk("core_rx_done", {31'd0, core_rx_done}, {31'd0, core_sel && uart_if.rx_done});
      chk("core_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    fetch_req       = 1'b0;
    core_sel        = 1'b0;
    uart_if.rx_done = 1'b0;

    plan_n = '{RXB};
    do_fetch(12'h3C7, 32'hCAFEF00D, 1);
    plan_n = '{RXB};
    do_fetch(12'h2A5, 32'h89ABCDEF, -1);

    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 9);
      nf  = (sel <= 5) ? 0 : (sel <= 7) ? 1 : (sel == 8) ? MR : MR + 1;
      plan_n.delete();
      for (int a = 0; a < nf; a++) plan_n.push_back($urandom_range(0, RXB - 1));
      if (nf <= MR) plan_n.push_back(RXB);
      do_fetch(AW'($urandom), $urandom, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bitty_uart_fetcher.md
# bitty_uart_fetcher

Parametrised UART instruction-fetch and link-arbitration unit for the Bitty system. It fetches one instruction word from the host by sending a read command plus address over the shared UART, then assembles the multi-byte reply. Each reply byte is guarded by a timeout with bounded retry. When idle, it hands the UART link to the Bitty core for its own rx/tx traffic. It sits between the control FSM/PC and the UART, and replaces the fixed 16-bit fetch path and the ad-hoc tx mux.

## Interface
Parameters:
- ADDR_W, 8, address width in bits (1..32); sent as ceil(ADDR_W/8) bytes, MSB first, zero-padded
- INSTR_W, 16, instruction width; must be a multiple of 8 (8..32); received as INSTR_W/8 bytes, MSB first
- TIMEOUT_CYC, 65535, idle clocks allowed between reply bytes before a retry
- MAX_RETRY, 3, retries after the first attempt before declaring an error
- CMD_READ, 8'h03, command byte opening every fetch

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  request a fetch; sampled only in IDLE
- fetch_addr  in  ADDR_W  address; captured when fetch_req is accepted
- instr_out  out  INSTR_W  last successfully fetched word; held until the next success
- fetch_done  out  1  one-cycle pulse: instr_out updated
- fetch_err  out  1  one-cycle pulse: retries exhausted
- busy  out  1  high in every state except IDLE
- err_count  out  8  count of fetch_err events, saturating at 255
- core_sel  in  1  core requests the UART link
- core_tx_en  in  1  core tx start, passed through when the core owns the link
- core_tx_data  in  8  core tx byte
- core_rx_done  out  1  rx_done gated to the core
- tx_en  out  1  UART tx start
- tx_data  out  8  UART tx byte
- tx_done  in  1  UART tx complete pulse
- rx_done  in  1  UART byte-received pulse
- rx_data  in  8  UART received byte

## Operation
- States: IDLE, SEND, WAIT_TX, RECV, DONE, ERR.
- IDLE:
  - If core_sel=1, the core owns the link: tx_en=core_tx_en, tx_data=core_tx_data, core_rx_done=rx_done.
  - Otherwise tx_en=0, core_rx_done=0, and received bytes are discarded.
  - fetch_req=1 with core_sel=0 latches fetch_addr, clears byte index and retry count, and moves to SEND. With core_sel=1 the request is ignored (core has priority).
- SEND: drives tx_en=1 for exactly one cycle. tx_data is CMD_READ at index 0, then address bytes MSB first. Next state is WAIT_TX.
- WAIT_TX: on tx_done, return to SEND if bytes remain, else go to RECV with the rx index at 0 and the timeout counter at 0.
- RECV:
  - On rx_done: shift rx_data into the assembly register MSB first, increment the rx index, and clear the timeout counter. After the last byte go to DONE.
  - With no byte, the counter increments. When it reaches TIMEOUT_CYC:
    - retry < MAX_RETRY: retry++, discard the partial word, restart at SEND index 0.
    - otherwise go to ERR.
- DONE: instr_out <= assembled word, fetch_done=1, then IDLE.
- ERR: fetch_err=1, err_count++ (saturating), instr_out unchanged, then IDLE.
- While busy, core_tx_en is ignored, core_rx_done=0, and tx_en/tx_data are owned by the fetcher. rx_done outside RECV is ignored.
- Reset (any state, mid-byte included): state IDLE; instr_out=0, err_count=0, all pulses 0, counters 0.

## Timing
- All outputs are registered except the IDLE passthrough paths (tx_en, tx_data, core_rx_done), which are combinational from core_sel/core_tx_*/rx_done.
- fetch_req accepted at edge N: busy=1 and tx_en=1 (CMD_READ) in cycle N+1.
- The next tx_en follows one cycle after the tx_done cycle.
- The last rx_done at edge M: fetch_done=1 and the new instr_out visible in cycle M+1; busy=0 in cycle M+2.
- A new fetch_req may be accepted in the same cycle busy falls.
- The timeout fires exactly TIMEOUT_CYC cycles after entering RECV or after the last received byte.
- rx_done in the same cycle the counter reaches TIMEOUT_CYC: the byte is taken and there is no retry.
- Total cycles to err on a silent host is roughly (MAX_RETRY+1) × (tx time + TIMEOUT_CYC).

## Test plan
- Defaults, fetch_addr=8'h2A; host returns 8'hC3, 8'h5B -> tx bytes 03,2A in order; instr_out=16'hC35B; fetch_done a single pulse; err_count=0.
- INSTR_W=32, ADDR_W=12, addr=12'hABC; reply 01 02 03 04 -> tx 03,0A,BC; instr_out=32'h01020304.
- TIMEOUT_CYC=100; host silent after the first reply byte on attempt 1, then a full reply -> one retry; tx 03,addr resent; the partial byte is discarded; the final word is correct.
- Host never replies, MAX_RETRY=3 -> exactly 4 command sequences; fetch_err pulse; err_count=1; instr_out keeps its prior value.
- core_sel=1 with fetch_req=1 in IDLE -> fetch ignored; core_tx_en/core_tx_data appear on tx_en/tx_data; rx_done mirrored on core_rx_done.
- Assert reset mid-RECV after one byte -> all outputs reset immediately; the next fetch completes normally.
